// File: rtl/requant_pkg.sv
// Shared constants, header layout and FSM state type for the requant_pack slice.
package requant_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned PACK   = 4;
   localparam int unsigned WORD_W = 64;

   localparam logic [7:0]  HDR_MAGIC     = 8'hA5;
   localparam int unsigned HDR_MAGIC_LSB = 56;
   localparam int unsigned HDR_SHIFT_LSB = 50;
   localparam int unsigned HDR_SHIFT_W   = 6;
   localparam int unsigned HDR_SAT_LSB   = 32;
   localparam int unsigned HDR_SAT_W     = 16;
   localparam int unsigned HDR_SPEC_LSB  = 0;
   localparam int unsigned HDR_SPEC_W    = 32;

   typedef enum logic {
      WAIT_SYNC,
      DATA
   } state_e;

   function automatic logic [WORD_W-1:0] make_hdr(
      input logic [HDR_SHIFT_W-1:0] shift,
      input logic [HDR_SAT_W-1:0]   sat,
      input logic [HDR_SPEC_W-1:0]  spec
   );
      return {HDR_MAGIC, shift, 2'b00, sat, spec};
   endfunction

endpackage

// File: rtl/requant_pack_sat8.sv
// Combinational unsigned saturator from DIN_WIDTH bits to one byte, with clip flag.
module requant_sat8 #(
   parameter int unsigned DIN_WIDTH = 32
) (
   input  logic [DIN_WIDTH-1:0] din,
   output logic [7:0]           dout,
   output logic                 clip
);

   always_comb begin
      clip = (din > DIN_WIDTH'(255));
      dout = clip ? '1 : din[7:0];
   end

endmodule

// File: rtl/requant_pack.sv
// Requantise two power streams to 8 bits, pack 4 channel pairs per 64-bit word and
// emit a per-spectrum header. Saturation counting is built only with REQUANT_SATCNT_EN.
module requant_pack #(
   parameter int unsigned DIN_WIDTH   = 32,
   parameter int unsigned SHIFT_WIDTH = 6,
   parameter int unsigned CHANNELS    = 2048
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [DIN_WIDTH-1:0]   din1,
   input  logic [DIN_WIDTH-1:0]   din2,
   input  logic                   din_valid,
   input  logic                   sync_in,
   input  logic [SHIFT_WIDTH-1:0] shift_val,
   output logic [63:0]            dout,
   output logic                   dout_valid,
   output logic                   dout_hdr,
   output logic                   dout_last,
   output logic                   sync_err
);
   import requant_pkg::*;

   localparam int unsigned CH_W = $clog2(CHANNELS);

   logic [7:0]  byte1, byte2;
   logic        clip1, clip2;
   logic [15:0] pair;
   logic        sync_evt;
   logic [HDR_SAT_W-1:0] sat_hdr;

   state_e      state_q, state_d;
   logic [CH_W-1:0] ch_cnt_q, ch_cnt_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic [31:0] spec_q, spec_d, spec_hdr;
   logic [63:0] dout_q, dout_d;
   logic        dout_valid_q, dout_valid_d;
   logic        dout_hdr_q, dout_hdr_d;
   logic        dout_last_q, dout_last_d;
   logic        sync_err_q, sync_err_d;

   requant_sat8 #(.DIN_WIDTH(DIN_WIDTH)) u_sat1 (.din(din1), .dout(byte1), .clip(clip1));
   requant_sat8 #(.DIN_WIDTH(DIN_WIDTH)) u_sat2 (.din(din2), .dout(byte2), .clip(clip2));

   assign pair = {byte1, byte2};
   // Channel 0 of a spectrum never sits in DATA, so any qualified sync there is early.
   assign sync_evt = din_valid && sync_in;

`ifdef REQUANT_SATCNT_EN
   logic [HDR_SAT_W-1:0] sat_q, sat_d, sat_base;
   logic [HDR_SAT_W:0]   sat_sum;
   logic                 accept;

   always_comb begin
      accept   = sync_evt || (din_valid && (state_q == DATA));
      sat_base = sync_evt ? '0 : sat_q;
      sat_sum  = {1'b0, sat_base} + (HDR_SAT_W+1)'(clip1) + (HDR_SAT_W+1)'(clip2);
      sat_d    = sat_q;
      if (accept) begin
         sat_d = sat_sum[HDR_SAT_W] ? '1 : sat_sum[HDR_SAT_W-1:0];
      end
      sat_hdr  = sat_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sat_q <= '0;
      else        sat_q <= sat_d;
   end
`else
   logic unused_clip;
   assign unused_clip = clip1 ^ clip2;
   assign sat_hdr     = '0;
`endif

   always_comb begin
      state_d      = state_q;
      ch_cnt_d     = ch_cnt_q;
      word_d       = word_q;
      spec_d       = spec_q;
      spec_hdr     = spec_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      dout_hdr_d   = 1'b0;
      dout_last_d  = 1'b0;
      sync_err_d   = sync_err_q;

      if (sync_evt) begin
         if (state_q == DATA) begin
            sync_err_d = 1'b1;
            spec_d     = spec_q + 32'd1;
            spec_hdr   = spec_q + 32'd1;
         end
         dout_d       = make_hdr(HDR_SHIFT_W'(shift_val), sat_hdr, spec_hdr);
         dout_valid_d = 1'b1;
         dout_hdr_d   = 1'b1;
         word_d       = {pair, 48'h0};
         ch_cnt_d     = CH_W'(1);
         state_d      = DATA;
      end else if (din_valid && (state_q == DATA)) begin
         case (ch_cnt_q[1:0])
            2'd0:    word_d[63:48] = pair;
            2'd1:    word_d[47:32] = pair;
            2'd2:    word_d[31:16] = pair;
            default: word_d[15:0]  = pair;
         endcase
         ch_cnt_d = ch_cnt_q + CH_W'(1);
         if (ch_cnt_q[1:0] == 2'd3) begin
            dout_d       = word_d;
            dout_valid_d = 1'b1;
         end
         if (ch_cnt_q == CH_W'(CHANNELS-1)) begin
            dout_last_d = 1'b1;
            spec_d      = spec_q + 32'd1;
            state_d     = WAIT_SYNC;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= WAIT_SYNC;
         ch_cnt_q     <= '0;
         word_q       <= '0;
         spec_q       <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         dout_hdr_q   <= 1'b0;
         dout_last_q  <= 1'b0;
         sync_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         ch_cnt_q     <= ch_cnt_d;
         word_q       <= word_d;
         spec_q       <= spec_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         dout_hdr_q   <= dout_hdr_d;
         dout_last_q  <= dout_last_d;
         sync_err_q   <= sync_err_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign dout_hdr   = dout_hdr_q;
   assign dout_last  = dout_last_q;
   assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_requant_pack.sv
// Directed, table-driven bench for requant_pack with CHANNELS=8.
module tb_requant_pack;

   localparam int unsigned CH = 8;
`ifdef REQUANT_SATCNT_EN
   localparam logic [15:0] SAT1 = 16'h0001;
`else
   localparam logic [15:0] SAT1 = 16'h0000;
`endif
   localparam logic [63:0] W0 = 64'h0001020304050607;
   localparam logic [63:0] W1 = 64'h08090A0B0C0D0E0F;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] din1, din2;
   logic        din_valid, sync_in;
   logic [5:0]  shift_val;
   logic [63:0] dout;
   logic        dout_valid, dout_hdr, dout_last, sync_err;

   always #5 clk = ~clk;

   requant_pack #(.DIN_WIDTH(32), .SHIFT_WIDTH(6), .CHANNELS(CH)) dut (
      .clk(clk), .rst_n(rst_n), .din1(din1), .din2(din2), .din_valid(din_valid),
      .sync_in(sync_in), .shift_val(shift_val), .dout(dout), .dout_valid(dout_valid),
      .dout_hdr(dout_hdr), .dout_last(dout_last), .sync_err(sync_err)
   );

   typedef struct {
      logic        v;
      logic        s;
      logic [5:0]  sh;
      logic [31:0] d1;
      logic [31:0] d2;
      logic        ev;
      logic        eh;
      logic        el;
      logic        ee;
      logic [63:0] ed;
   } vec_t;

   vec_t tbl[$];
   vec_t tbl2[$];
   int unsigned pass_cnt = 0;
   int unsigned total_cnt = 0;

   task automatic chk(input string name, input int unsigned idx,
                      input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s idx=%0d got=%h want=%h", name, idx, act, exp);
   endtask

   function automatic vec_t mk(input logic v, input logic s, input logic [5:0] sh,
                               input logic [31:0] d1, input logic [31:0] d2,
                               input logic ev, input logic eh, input logic el,
                               input logic ee, input logic [63:0] ed);
      vec_t e;
      e.v = v; e.s = s; e.sh = sh; e.d1 = d1; e.d2 = d2;
      e.ev = ev; e.eh = eh; e.el = el; e.ee = ee; e.ed = ed;
      return e;
   endfunction

   task automatic run_vec(input vec_t e, input int unsigned idx);
      din_valid = e.v; sync_in = e.s; shift_val = e.sh; din1 = e.d1; din2 = e.d2;
      @(posedge clk);
      #1;
      chk("valid", idx, 64'(dout_valid), 64'(e.ev));
      chk("hdr",   idx, 64'(dout_hdr),   64'(e.eh));
      chk("last",  idx, 64'(dout_last),  64'(e.el));
      chk("err",   idx, 64'(sync_err),   64'(e.ee));
      if (e.ev) chk("dout", idx, dout, e.ed);
   endtask

   initial begin
      // Spectrum 0: normal, shift 5.
      for (int k = 0; k < 8; k++)
         tbl.push_back(mk(1'b1, k == 0, 6'd5, 32'(2*k), 32'(2*k+1),
                          k == 0 || k == 3 || k == 7, k == 0, k == 7, 1'b0,
                          k == 0 ? 64'hA514000000000000 : (k == 3 ? W0 : W1)));
      // Spectrum 1: ch2 din1 clips, din2=255 does not; sync right after previous last.
      for (int k = 0; k < 8; k++)
         tbl.push_back(mk(1'b1, k == 0, 6'd5, k == 2 ? 32'd300 : 32'(2*k),
                          k == 2 ? 32'd255 : 32'(2*k+1),
                          k == 0 || k == 3 || k == 7, k == 0, k == 7, 1'b0,
                          k == 0 ? 64'hA514000000000001 : (k == 3 ? 64'h00010203FFFF0607 : W1)));
      // Spectrum 2: gapped valid with unqualified sync/garbage on the idle cycles.
      for (int k = 0; k < 8; k++) begin
         tbl.push_back(mk(1'b1, k == 0, 6'd63, 32'(2*k), 32'(2*k+1),
                          k == 0 || k == 3 || k == 7, k == 0, k == 7, 1'b0,
                          k == 0 ? {8'hA5, 8'hFC, SAT1, 32'd2} : (k == 3 ? W0 : W1)));
         tbl.push_back(mk(1'b0, 1'b1, 6'd63, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                          1'b0, 1'b0, 1'b0, 1'b0, 64'h0));
      end
      // Spectrum 3: early sync after 6 channels; restarts as spectrum 4.
      for (int k = 0; k < 6; k++)
         tbl.push_back(mk(1'b1, k == 0, 6'd5, 32'(2*k), 32'(2*k+1),
                          k == 0 || k == 3, k == 0, 1'b0, 1'b0,
                          k == 0 ? 64'hA514000000000003 : W0));
      for (int k = 0; k < 8; k++)
         tbl.push_back(mk(1'b1, k == 0, 6'd5, 32'(2*k), 32'(2*k+1),
                          k == 0 || k == 3 || k == 7, k == 0, k == 7, 1'b1,
                          k == 0 ? 64'hA514000000000004 : (k == 3 ? W0 : W1)));
      // Missing sync: extra channels are ignored.
      for (int k = 0; k < 4; k++)
         tbl.push_back(mk(1'b1, 1'b0, 6'd5, 32'(2*k), 32'(2*k+1),
                          1'b0, 1'b0, 1'b0, 1'b1, 64'h0));

      // After a mid-spectrum reset: unsynced samples ignored, then fresh counters.
      for (int k = 0; k < 4; k++)
         tbl2.push_back(mk(1'b1, 1'b0, 6'd0, 32'(2*k), 32'(2*k+1),
                           1'b0, 1'b0, 1'b0, 1'b0, 64'h0));
      for (int k = 0; k < 8; k++)
         tbl2.push_back(mk(1'b1, k == 0, 6'd0, k == 0 ? 32'd1000 : 32'(2*k),
                           k == 0 ? 32'd2 : 32'(2*k+1),
                           k == 0 || k == 3 || k == 7, k == 0, k == 7, 1'b0,
                           k == 0 ? 64'hA500000000000000 : (k == 3 ? 64'hFF02020304050607 : W1)));
      tbl2.push_back(mk(1'b1, 1'b1, 6'd0, 32'd0, 32'd1, 1'b1, 1'b1, 1'b0, 1'b0,
                        {8'hA5, 8'h00, SAT1, 32'd1}));

      rst_n = 1'b0; din_valid = 1'b0; sync_in = 1'b0; shift_val = '0; din1 = '0; din2 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_dout",  0, dout, 64'h0);
      chk("rst_valid", 0, 64'(dout_valid), 64'h0);
      chk("rst_hdr",   0, 64'(dout_hdr),   64'h0);
      chk("rst_last",  0, 64'(dout_last),  64'h0);
      chk("rst_err",   0, 64'(sync_err),   64'h0);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

      // Partial spectrum, then asynchronous reset must clear outputs at once.
      run_vec(mk(1'b1, 1'b1, 6'd5, 32'd0, 32'd1, 1'b1, 1'b1, 1'b0, 1'b1,
                 64'hA514000000000005), 100);
      run_vec(mk(1'b1, 1'b0, 6'd5, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0), 101);
      run_vec(mk(1'b1, 1'b0, 6'd5, 32'd4, 32'd5, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0), 102);
      din_valid = 1'b0; sync_in = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("arst_err",   103, 64'(sync_err),   64'h0);
      chk("arst_dout",  103, dout, 64'h0);
      chk("arst_valid", 103, 64'(dout_valid), 64'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < tbl2.size(); i++) run_vec(tbl2[i], 200 + i);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
